// File: rtl/mul_div_resp_collector.sv
// ---------------------------------------------------------------------------
// mul_div_resp_collector
//
// Response-side companion to mul_div. Every operation issued on `en` is
// tracked through a LATENCY-stage tag pipeline. When its tag reaches the last
// stage, the block captures mul_div's result and exception flags into a small
// result FIFO. The FIFO drains through a valid/ready port. The block also
// keeps IEEE-style sticky exception status and a saturating drop counter.
// It produces an issue credit so that the issuing side can avoid overrunning
// the queue.
//
// Parameters
//   LATENCY : cycles from `en` sampled high to R/flags valid (1..8)
//   DEPTH   : result FIFO entries, power of 2 (2..16)
//
// Ports
//   clk, arst            : clock and synchronous active-high reset
//   en, sel              : issue strobe and op select (0 mul, 1 div)
//   R, IO/DZ/OF/UF/I     : mul_div result and exception flags
//   issue_ok             : credit; an issue this cycle is guaranteed a slot
//   out_valid/out_ready  : result port handshake
//   out_r/out_sel/out_flags : head entry, flags ordered {IO,DZ,OF,UF,I}
//   sticky, sticky_clr   : accumulated flags and their clear
//   drop_cnt             : saturating count of results lost to a full FIFO
//
// Handshake: a transfer happens on a rising edge where out_valid && out_ready.
// out_valid never depends on out_ready. The head fields hold steady while
// out_valid=1 and out_ready=0.
// ---------------------------------------------------------------------------
module mul_div_resp_collector #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        en,
    input  logic        sel,
    input  logic [31:0] R,
    input  logic        IO,
    input  logic        DZ,
    input  logic        OF,
    input  logic        UF,
    input  logic        I,
    output logic        issue_ok,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_r,
    output logic        out_sel,
    output logic [4:0]  out_flags,
    output logic [4:0]  sticky,
    input  logic        sticky_clr,
    output logic [7:0]  drop_cnt
);

    localparam int         AW      = $clog2(DEPTH);
    localparam int         CW      = AW + 1;
    localparam logic [5:0] L_DEPTH = 6'(DEPTH);

    // Tag pipeline: stage 0 holds the issue sampled at the latest edge.
    logic [LATENCY-1:0] r_tag_v;
    logic [LATENCY-1:0] r_tag_sel;

    // Result FIFO storage and bookkeeping.
    logic [31:0]        r_mem_r     [DEPTH];
    logic [DEPTH-1:0]   r_mem_sel;
    logic [4:0]         r_mem_flags [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic [4:0]         r_sticky;
    logic [7:0]         r_drop_cnt;

    logic [4:0]         w_flags;
    logic               w_capture;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [5:0]         w_inflight;

    assign w_flags   = {IO, DZ, OF, UF, I};
    assign w_capture = r_tag_v[LATENCY-1];
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = out_valid && out_ready;
    // A full FIFO can still accept an entry when the head leaves on the same edge.
    assign w_push    = w_capture && (!w_full || w_pop);
    assign w_drop    = w_capture && !w_push;

    // Count every valid tag stage, including the one capturing this cycle.
    // The capturing tag moves into the FIFO on the same edge, so the total
    // credit usage stays constant across that transfer.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            w_inflight = w_inflight + 6'(r_tag_v[i]);
        end
    end

    assign issue_ok  = (w_inflight + 6'(r_count)) < L_DEPTH;
    assign out_valid = (r_count != '0);
    assign out_r     = r_mem_r[r_rd_ptr];
    assign out_sel   = r_mem_sel[r_rd_ptr];
    assign out_flags = r_mem_flags[r_rd_ptr];
    assign sticky    = r_sticky;
    assign drop_cnt  = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_tag_v    <= '0;
            r_tag_sel  <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sticky   <= '0;
            r_drop_cnt <= '0;
            r_mem_sel  <= '0;
            // Storage is cleared so the head fields read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_r[i]     <= '0;
                r_mem_flags[i] <= '0;
            end
        end else begin
            r_tag_v[0]   <= en;
            r_tag_sel[0] <= sel;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_v[i]   <= r_tag_v[i-1];
                r_tag_sel[i] <= r_tag_sel[i-1];
            end

            if (w_push) begin
                r_mem_r[r_wr_ptr]     <= R;
                r_mem_sel[r_wr_ptr]   <= r_tag_sel[LATENCY-1];
                r_mem_flags[r_wr_ptr] <= w_flags;
                r_wr_ptr              <= r_wr_ptr + AW'(1);
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end

            // Dropped captures still update sticky. A capture on the same
            // edge as a clear wins, leaving only the captured flags.
            if (w_capture) begin
                r_sticky <= sticky_clr ? w_flags : (r_sticky | w_flags);
            end else if (sticky_clr) begin
                r_sticky <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_resp_collector.sv
// ---------------------------------------------------------------------------
// Bench for mul_div_resp_collector (LATENCY=2, DEPTH=4).
// The reference model tracks issued operations by the edge on which each was
// issued. It keeps a queue of result records and mirrors the sticky and drop
// bookkeeping. Every cycle it compares the model against the DUT outputs, and
// directed sequences add constant expectations for corner cases.
// ---------------------------------------------------------------------------
module tb_mul_div_resp_collector;

  localparam int LATENCY = 2;
  localparam int DEPTH   = 4;

  logic        clk;
  logic        arst;
  logic        en;
  logic        sel;
  logic [31:0] r_in;
  logic [4:0]  flags_in;
  logic        issue_ok;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic        out_sel;
  logic [4:0]  out_flags;
  logic [4:0]  sticky;
  logic        sticky_clr;
  logic [7:0]  drop_cnt;

  mul_div_resp_collector #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .arst       (arst),
    .en         (en),
    .sel        (sel),
    .R          (r_in),
    .IO         (flags_in[4]),
    .DZ         (flags_in[3]),
    .OF         (flags_in[2]),
    .UF         (flags_in[1]),
    .I          (flags_in[0]),
    .issue_ok   (issue_ok),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_r      (out_r),
    .out_sel    (out_sel),
    .out_flags  (out_flags),
    .sticky     (sticky),
    .sticky_clr (sticky_clr),
    .drop_cnt   (drop_cnt)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_vec;
  int n_err;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] r;
    logic        s;
    logic [4:0]  f;
  } ent_t;

  ent_t       m_q[$];           // results waiting in the FIFO, head first
  int         m_issue_edge[$];  // edge index of each outstanding issue
  logic       m_issue_sel[$];
  int         m_edge;
  logic [4:0] m_sticky;
  int         m_drop;
  bit         m_zero_head;      // head fields read 0 until the first push after reset

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("out_r", out_r, m_q[0].r);
      chk("out_sel", 32'(out_sel), 32'(m_q[0].s));
      chk("out_flags", 32'(out_flags), 32'(m_q[0].f));
    end else if (m_zero_head) begin
      chk("out_r_zero", out_r, 32'd0);
      chk("out_sel_zero", 32'(out_sel), 32'd0);
      chk("out_flags_zero", 32'(out_flags), 32'd0);
    end
    chk("issue_ok", 32'(issue_ok), 32'((m_issue_edge.size() + m_q.size()) < DEPTH));
    chk("sticky", 32'(sticky), 32'(m_sticky));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  // Drive one cycle from the negedge. The model advances for the coming edge,
  // then the DUT is compared at the following negedge.
  task automatic cycle(input bit e, input bit s, input logic [31:0] r, input logic [4:0] f,
                       input bit rdy, input bit clr, input bit rst);
    bit   cap;
    bit   pop;
    logic csel;
    en = e; sel = s; r_in = r; flags_in = f;
    out_ready = rdy; sticky_clr = clr; arst = rst;
    m_edge++;
    if (rst) begin
      m_q.delete();
      m_issue_edge.delete();
      m_issue_sel.delete();
      m_sticky    = '0;
      m_drop      = 0;
      m_zero_head = 1'b1;
    end else begin
      cap  = 1'b0;
      csel = 1'b0;
      if (m_issue_edge.size() > 0 && m_issue_edge[0] + LATENCY == m_edge) begin
        cap  = 1'b1;
        csel = m_issue_sel[0];
        void'(m_issue_edge.pop_front());
        void'(m_issue_sel.pop_front());
      end
      pop = (m_q.size() > 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (cap) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back('{r: r, s: csel, f: f});
          m_zero_head = 1'b0;
        end else if (m_drop < 255) begin
          m_drop++;
        end
        m_sticky = clr ? f : (m_sticky | f);
      end else if (clr) begin
        m_sticky = '0;
      end
      if (e) begin
        m_issue_edge.push_back(m_edge);
        m_issue_sel.push_back(s);
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 32'd0, 5'd0, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        s;
    logic [31:0] r;
    logic [4:0]  f;
    logic [4:0]  exp_sticky;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int          issues;
    logic [31:0] prev_r;
    logic [31:0] last_r;

    n_vec = 0; n_err = 0; m_edge = 0;
    m_sticky = '0; m_drop = 0; m_zero_head = 1'b1;
    en = 0; sel = 0; r_in = 0; flags_in = 0; out_ready = 0; sticky_clr = 0; arst = 1;

    // Sticky accumulates across the table, with no clear between rows.
    tbl[0] = '{s: 1'b0, r: 32'h3F800000, f: 5'b00000, exp_sticky: 5'b00000};
    tbl[1] = '{s: 1'b1, r: 32'h7F800000, f: 5'b01000, exp_sticky: 5'b01000};
    tbl[2] = '{s: 1'b0, r: 32'h00000001, f: 5'b00011, exp_sticky: 5'b01011};
    tbl[3] = '{s: 1'b1, r: 32'h7FC00000, f: 5'b10000, exp_sticky: 5'b11011};
    tbl[4] = '{s: 1'b0, r: 32'h7F7FFFFF, f: 5'b00101, exp_sticky: 5'b11111};

    @(negedge clk);

    // ---- reset state ----
    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_issue_ok", 32'(issue_ok), 32'd1);
    chk("rst_out_r", out_r, 32'd0);

    // ---- single op: issue at edge 0, capture at edge 2 ----
    cycle(1'b1, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("single_not_early1", 32'(out_valid), 32'd0);
    idle(1'b0);
    chk("single_not_early2", 32'(out_valid), 32'd0);
    cycle(1'b0, 1'b0, 32'h40C00000, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_r", out_r, 32'h40C00000);
    chk("single_sel", 32'(out_sel), 32'd0);
    chk("single_flags", 32'(out_flags), 32'd0);
    idle(1'b1);
    chk("single_popped", 32'(out_valid), 32'd0);

    // ---- table-driven single ops ----
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, tbl[k].s, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      cycle(1'b0, 1'b0, tbl[k].r, tbl[k].f, 1'b0, 1'b0, 1'b0);
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_r", out_r, tbl[k].r);
      chk("tbl_sel", 32'(out_sel), 32'(tbl[k].s));
      chk("tbl_flags", 32'(out_flags), 32'(tbl[k].f));
      chk("tbl_sticky", 32'(sticky), 32'(tbl[k].exp_sticky));
      idle(1'b1);
      chk("tbl_empty", 32'(out_valid), 32'd0);
    end

    // ---- fill/credit: issue only while issue_ok ----
    do_reset();
    issues = 0;
    for (int i = 0; i < 8; i++) begin
      if (issue_ok) begin
        issues++;
        cycle(1'b1, i[0], 32'h1000 + 32'(i), 5'd0, 1'b0, 1'b0, 1'b0);
      end else begin
        cycle(1'b0, 1'b0, 32'h1000 + 32'(i), 5'd0, 1'b0, 1'b0, 1'b0);
      end
    end
    chk("fill_issues", 32'(issues), 32'd4);
    chk("fill_issue_ok", 32'(issue_ok), 32'd0);
    chk("fill_drop", 32'(drop_cnt), 32'd0);
    prev_r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_order", 32'(out_r > prev_r), 32'd1);
      prev_r = out_r;
      idle(1'b1);
    end
    chk("fill_drained", 32'(out_valid), 32'd0);

    // ---- overrun: six issues into a four-entry queue ----
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle(i < 6, 1'b0, 32'h2000 + 32'(i),
            (i == 6) ? 5'b00010 : ((i == 7) ? 5'b00001 : 5'b00000),
            1'b0, 1'b0, 1'b0);
    end
    chk("ovr_drop", 32'(drop_cnt), 32'd2);
    chk("ovr_sticky", 32'(sticky), 32'b00011);
    chk("ovr_valid", 32'(out_valid), 32'd1);

    // ---- full push+pop on the same edge ----
    cycle(1'b1, 1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    cycle(1'b0, 1'b0, 32'hABCD0000, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("pp_drop", 32'(drop_cnt), 32'd2);
    chk("pp_full", 32'(issue_ok), 32'd0);
    last_r = 32'd0;
    for (int i = 0; i < 4; i++) begin
      last_r = out_r;
      idle(1'b1);
    end
    chk("pp_tail", last_r, 32'hABCD0000);
    chk("pp_empty", 32'(out_valid), 32'd0);

    // ---- sticky set / clear / clear-with-capture ----
    do_reset();
    cycle(1'b1, 1'b1, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    cycle(1'b0, 1'b0, 32'h7F800000, 5'b01000, 1'b1, 1'b0, 1'b0);
    chk("st_dz", 32'(sticky), 32'b01000);
    chk("st_dz_sel", 32'(out_sel), 32'd1);
    cycle(1'b0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    chk("st_clr", 32'(sticky), 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    cycle(1'b0, 1'b0, 32'h7F7FFFFF, 5'b00100, 1'b1, 1'b1, 1'b0);
    chk("st_clr_set", 32'(sticky), 32'b00100);

    // ---- reset mid-operation: 2 queued + 1 in flight ----
    do_reset();
    cycle(1'b1, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'h11111111, 5'b10000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h22222222, 5'b00001, 1'b0, 1'b0, 1'b0);
    chk("mid_pre_valid", 32'(out_valid), 32'd1);
    cycle(1'b1, 1'b1, 32'h33333333, 5'b11111, 1'b0, 1'b0, 1'b1);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_r", out_r, 32'd0);
    chk("mid_sel", 32'(out_sel), 32'd0);
    chk("mid_flags", 32'(out_flags), 32'd0);
    chk("mid_sticky", 32'(sticky), 32'd0);
    chk("mid_drop", 32'(drop_cnt), 32'd0);
    chk("mid_issue_ok", 32'(issue_ok), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 32'h44444444, 5'b11111, 1'b0, 1'b0, 1'b0);
    end
    chk("mid_no_ghost", 32'(out_valid), 32'd0);
    chk("mid_no_ghost_sticky", 32'(sticky), 32'd0);

    // ---- drop counter saturation ----
    do_reset();
    for (int i = 0; i < 270; i++) begin
      cycle(1'b1, 1'b0, $urandom, 5'd0, 1'b0, 1'b0, 1'b0);
    end
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // ---- randomized traffic against the model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 6,
            1'($urandom_range(0, 1)),
            $urandom,
            5'($urandom_range(0, 31) & $urandom_range(0, 31)),
            $urandom_range(0, 9) < 5,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
